// File: rtl/kernel_bank.sv
// kernel_bank: double-buffered convolution coefficient store with per-bank running sums
module kernel_bank #(
  parameter int DATA_W = 4,
  parameter int TAPS   = 9,
  parameter int ADDR_W = 4,
  parameter int SUM_W  = DATA_W + 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              active_bank,
  output logic [SUM_W-1:0]  active_sum
);

  localparam logic [ADDR_W:0] TAPS_L = (ADDR_W + 1)'(TAPS);

  function automatic logic [DATA_W-1:0] dflt(input int i);
    return (i % 4 == 1) ? DATA_W'(2) : (i % 4 == 3) ? DATA_W'(0) : DATA_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] dsum();
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < TAPS; i++) s = s + SUM_W'(dflt(i));
    return s;
  endfunction

  localparam logic [SUM_W-1:0] DSUM = dsum();

  typedef enum logic {IDLE, PENDING} state_t;

  state_t            state_q, state_d;
  logic              act_q, act_d;
  logic [DATA_W-1:0] bank_q [2][TAPS];
  logic [DATA_W-1:0] bank_d [2][TAPS];
  logic [SUM_W-1:0]  sum_q [2];
  logic [SUM_W-1:0]  sum_d [2];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_ok, swap;

  // Swaps only on an edge without a read, so a read never straddles banks
  always_comb begin
    wr_ok      = wr_en && ({1'b0, wr_addr} < TAPS_L);
    swap       = !rd_en && (state_q == PENDING || swap_req);
    state_d    = (state_q == IDLE && swap_req && rd_en) ? PENDING :
                 (state_q == PENDING && !rd_en) ? IDLE : state_q;
    act_d      = act_q ^ swap;
    bank_d     = bank_q;
    sum_d      = sum_q;
    if (wr_ok) begin
      bank_d[~act_q][wr_addr] = wr_data;
      sum_d[~act_q] = sum_q[~act_q] - SUM_W'(bank_q[~act_q][wr_addr]) + SUM_W'(wr_data);
    end
    rd_valid_d = rd_en;
    rd_data_d  = !rd_en ? rd_data_q :
                 ({1'b0, rd_addr} < TAPS_L) ? bank_q[act_q][rd_addr] : '0;
    wr_err_d   = wr_en && !wr_ok;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= IDLE;
      act_q      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        bank_q[0][i] <= dflt(i);
        bank_q[1][i] <= dflt(i);
      end
      sum_q[0]   <= DSUM;
      sum_q[1]   <= DSUM;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      bank_q     <= bank_d;
      sum_q      <= sum_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign wr_err       = wr_err_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign swap_pending = (state_q == PENDING);
  assign active_bank  = act_q;
  assign active_sum   = sum_q[act_q];

endmodule

// File: tb/tb_kernel_bank.sv
// tb_kernel_bank: directed stimulus with a read-data scoreboard checked by an independent monitor
module tb_kernel_bank;
  logic       CLK = 1'b0, CLR = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, swap_req = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0, wr_data = '0;
  logic       wr_err, rd_valid, swap_pending, active_bank;
  logic [3:0] rd_data;
  logic [7:0] active_sum;
  int         checks = 0, errors = 0;
  logic [3:0] exp_q [$];
  logic [3:0] dk [9] = '{1, 2, 1, 0, 1, 2, 1, 0, 1};

  kernel_bank dut (
    .CLK(CLK), .CLR(CLR), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .swap_req(swap_req), .swap_pending(swap_pending),
    .active_bank(active_bank), .active_sum(active_sum)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd(input int a, input logic [3:0] e);
    rd_en = 1'b1;
    rd_addr = 4'(a);
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_data %0d with no read outstanding", rd_data);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    CLR = 1'b0;
    chk("reset_bank", active_bank, 0);
    chk("reset_sum", active_sum, 9);
    chk("reset_pending", swap_pending, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_wr_err", wr_err, 0);
    for (int i = 0; i < 9; i++) begin rd(i, dk[i]); tick(); end
    rd_en = 1'b0; tick();
    chk("idle_valid", rd_valid, 0);
    chk("hold_rd_data", rd_data, 1);
    wr_en = 1'b1; wr_data = 4'hF;
    for (int i = 0; i < 9; i++) begin wr_addr = 4'(i); tick(); end
    wr_en = 1'b0;
    chk("write_no_active_sum", active_sum, 9);
    chk("write_no_active_bank", active_bank, 0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("swap1_bank", active_bank, 1);
    chk("swap1_sum", active_sum, 135);
    chk("swap1_pending", swap_pending, 0);
    for (int i = 0; i < 9; i++) begin rd(i, 4'hF); tick(); end
    rd_en = 1'b0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("swap2_bank", active_bank, 0);
    chk("swap2_sum", active_sum, 9);
    for (int i = 0; i < 9; i++) begin rd(i, dk[i]); tick(); end
    for (int i = 0; i < 9; i++) begin
      rd(i, dk[i]);
      swap_req = (i == 0 || i == 4);
      tick();
      chk("burst_pending", swap_pending, 1);
      chk("burst_bank", active_bank, 0);
    end
    rd_en = 1'b0; swap_req = 1'b0; tick();
    chk("burst_swap_pending", swap_pending, 0);
    chk("burst_swap_bank", active_bank, 1);
    chk("burst_swap_sum", active_sum, 135);
    tick();
    chk("absorbed_bank", active_bank, 1);
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 4'd5; rd(10, 4'd0); tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_err_pulse", wr_err, 1);
    chk("oob_sum", active_sum, 135);
    tick();
    chk("wr_err_clear", wr_err, 0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 4'd7; swap_req = 1'b1; tick();
    wr_en = 1'b0; swap_req = 1'b0;
    chk("wrswap_bank", active_bank, 0);
    chk("wrswap_sum", active_sum, 15);
    rd(4, 4'd7); tick();
    rd(3, 4'd0); tick();
    rd(0, 4'd1); swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("pre_clr_pending", swap_pending, 1);
    rd_addr = 4'd4; CLR = 1'b1; tick(); CLR = 1'b0; rd_en = 1'b0;
    chk("clr_pending", swap_pending, 0);
    chk("clr_valid", rd_valid, 0);
    chk("clr_bank", active_bank, 0);
    chk("clr_sum", active_sum, 9);
    chk("clr_rd_data", rd_data, 0);
    for (int i = 0; i < 9; i++) begin rd(i, dk[i]); tick(); end
    rd_en = 1'b0; swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("clr_shadow_bank", active_bank, 1);
    chk("clr_shadow_sum", active_sum, 9);
    for (int i = 0; i < 9; i++) begin rd(i, dk[i]); tick(); end
    rd_en = 1'b0; tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_bank.md
Name: kernel_bank

Overview:
- Parametrised, double-buffered coefficient store for the convolution datapath.
- Replaces the fixed 3x3 4-bit kernel ROM with two writable banks:
  - an active bank, read by the MAC sequencer;
  - a shadow bank, loaded by the host.
- Banks exchange roles on a safe swap.
- Keeps a running coefficient sum per bank for downstream normalisation.

Parameters:
- DATA_W, 4, coefficient width in bits (unsigned).
- TAPS, 9, coefficients per kernel (e.g. 9 = 3x3, 25 = 5x5); 2..16.
- ADDR_W, 4, tap address width; must satisfy 2^ADDR_W >= TAPS.
- SUM_W, DATA_W+4, width of coefficient-sum outputs; holds TAPS*(2^DATA_W-1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- wr_en  in  1  write a coefficient into the shadow bank.
- wr_addr  in  ADDR_W  tap index for write.
- wr_data  in  DATA_W  coefficient value.
- wr_err  out  1  one-cycle pulse: write rejected (wr_addr >= TAPS).
- rd_en  in  1  read request on the active bank.
- rd_addr  in  ADDR_W  tap index for read.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data valid this cycle.
- swap_req  in  1  single-cycle request to exchange active/shadow.
- swap_pending  out  1  a swap is requested but not yet executed.
- active_bank  out  1  index (0/1) of the current active bank.
- active_sum  out  SUM_W  sum of all coefficients in the active bank.

Behaviour:
- Reset (CLR=1 at an edge), overriding all other inputs that cycle:
  - Both banks load the default kernel: tap i = {1,2,1,0}[i mod 4]. For TAPS=9 this is 1,2,1,0,1,2,1,0,1.
  - Both sums = sum of the defaults (9 for TAPS=9).
  - active_bank=0, rd_data=0, rd_valid=0, wr_err=0, swap_pending=0.
- Reset mid-operation:
  - Discards pending swaps, in-flight reads and same-cycle writes.
  - The next cycle sees post-reset state.
- Read, latency 1:
  - rd_en=1 at edge N gives rd_valid=1 and rd_data = active[rd_addr] after edge N.
  - Back-to-back reads are allowed, one per cycle.
  - rd_en=0: rd_valid=0; rd_data holds its last value.
  - rd_addr >= TAPS: rd_valid=1, rd_data=0.
- Write, 1 cycle:
  - wr_en=1 and wr_addr < TAPS: shadow[wr_addr] <= wr_data.
  - Same edge: shadow_sum <= shadow_sum - old + wr_data, using the SUM_W-bit result.
  - Out of range: no state change; wr_err=1 for one cycle after the edge.
  - Writes never touch the active bank or active_sum.
- Swap state machine, IDLE / PENDING:
  - IDLE: swap_req=1 and rd_en=0 → swap at this edge; stay IDLE.
  - IDLE: swap_req=1 and rd_en=1 → PENDING (swap_pending=1).
  - PENDING: first edge with rd_en=0 → swap, return to IDLE, swap_pending=0.
  - PENDING: further swap_req pulses are absorbed; at most one swap per pending episode.
  - Swap action: active_bank toggles; active_sum and shadow_sum exchange.
  - The new shadow bank holds the previous active contents; no copy is made.
- Write and swap at the same edge:
  - The write lands in the pre-swap shadow bank, i.e. the new active bank.
  - The new active_sum includes that write.
- Read and swap at the same edge:
  - Impossible by construction; the swap waits for rd_en=0.
  - In-flight data is therefore always taken from a single bank.
- Sums are combinationally consistent with bank contents at every cycle boundary, with no drift.

Test Plan:
- Reset, then read taps 0..8 back-to-back, TAPS=9 → rd_data 1,2,1,0,1,2,1,0,1, each 1 cycle after rd_en; active_sum=9; active_bank=0.
- Write shadow taps 0..8 = 4'hF, then swap_req with rd_en=0 → active_bank=1 next cycle; active_sum=135; reads return 15; bank 0 still reads 1,2,1,... after a second swap.
- swap_req during a continuous 9-tap read burst → swap_pending=1 through the burst; all 9 reads return old-bank data; swap executes on the first rd_en=0 cycle; swap_pending drops.
- wr_en with wr_addr=12, and rd_en with rd_addr=10 → wr_err pulses 1 cycle, no sum change; rd_valid=1 with rd_data=0.
- Write tap 4 = 7 in the same cycle as swap_req (rd_en=0) → new active tap 4 = 7; active_sum = 9 - 1 + 7 = 15.
- CLR asserted while swap_pending=1 and a read is in flight → next cycle swap_pending=0, rd_valid=0, active_bank=0, active_sum=9, all taps at default.
